// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and external memory port of mem_arbiter.
// The arbiter takes the slave view; the CPU/memory side takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] irdata;
  logic          iack;
  logic          istall;

  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata;
  logic          dack;
  logic          dstall;

  logic          mreq;
  logic          mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic [DW-1:0] mrdata;
  logic          mready;

  logic          err;
  logic          err_sticky;

  modport slave (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mready,
    output irdata, iack, istall, drdata, dack, dstall,
           mreq, mwe, maddr, mwdata, err, err_sticky
  );

  modport master (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mready,
    input  irdata, iack, istall, drdata, dack, dstall,
           mreq, mwe, maddr, mwdata, err, err_sticky
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the MIPS core.
// Data has fixed priority; every transaction is bounded by a busy-cycle timeout.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IBUSY = 2'd1;
  localparam logic [1:0] S_DBUSY = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          mreq_q, mreq_d;
  logic          mwe_q, mwe_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          iack_q, iack_d;
  logic          dack_q, dack_d;
  logic          err_q, err_d;
  logic          err_sticky_q, err_sticky_d;
  logic          ireq_m, dreq_m;

  // A port whose ack is high is masked, so the other waiting port wins that cycle.
  assign ireq_m = bus.ireq & ~iack_q;
  assign dreq_m = bus.dreq & ~dack_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mreq_d       = mreq_q;
    mwe_d        = mwe_q;
    maddr_d      = maddr_q;
    mwdata_d     = mwdata_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    iack_d       = 1'b0;
    dack_d       = 1'b0;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;

    case (state_q)
      S_IDLE: begin
        if (dreq_m) begin
          state_d  = S_DBUSY;
          mreq_d   = 1'b1;
          mwe_d    = bus.dwe;
          maddr_d  = bus.daddr;
          mwdata_d = bus.dwdata;
          cnt_d    = 8'd0;
        end else if (ireq_m) begin
          state_d  = S_IBUSY;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = bus.iaddr;
          cnt_d    = 8'd0;
        end
      end

      S_IBUSY, S_DBUSY: begin
        if (bus.mready) begin
          state_d = S_IDLE;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          if (state_q == S_IBUSY) begin
            iack_d   = 1'b1;
            irdata_d = bus.mrdata;
          end else begin
            dack_d = 1'b1;
            if (!mwe_q) drdata_d = bus.mrdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // The owner still gets its ack so the pipeline unfreezes, with all-ones data.
          state_d      = S_IDLE;
          mreq_d       = 1'b0;
          mwe_d        = 1'b0;
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
          if (state_q == S_IBUSY) begin
            iack_d   = 1'b1;
            irdata_d = '1;
          end else begin
            dack_d   = 1'b1;
            drdata_d = '1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        mreq_d  = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      mreq_q       <= 1'b0;
      mwe_q        <= 1'b0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
      iack_q       <= 1'b0;
      dack_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mreq_q       <= mreq_d;
      mwe_q        <= mwe_d;
      maddr_q      <= maddr_d;
      mwdata_q     <= mwdata_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
      iack_q       <= iack_d;
      dack_q       <= dack_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.mreq       = mreq_q;
  assign bus.mwe        = mwe_q;
  assign bus.maddr      = maddr_q;
  assign bus.mwdata     = mwdata_q;
  assign bus.irdata     = irdata_q;
  assign bus.drdata     = drdata_q;
  assign bus.iack       = iack_q;
  assign bus.dack       = dack_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.istall     = bus.ireq & ~iack_q;
  assign bus.dstall     = bus.dreq & ~dack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic we, input logic [31:0] da, input logic [31:0] dw);
    bus.ireq   = ir;
    bus.iaddr  = ia;
    bus.dreq   = dr;
    bus.dwe    = we;
    bus.daddr  = da;
    bus.dwdata = dw;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  // Memory responder: mready in busy cycle mem_delay, or forced regardless of mreq.
  int          mem_delay   = 0;
  logic [31:0] mem_data    = '0;
  logic        force_ready = 1'b0;
  int          busy_k      = 0;
  logic        prev_mreq   = 1'b0;

  initial begin
    bus.mready = 1'b0;
    bus.mrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mreq) busy_k = prev_mreq ? busy_k + 1 : 0;
      prev_mreq  = bus.mreq;
      bus.mready = force_ready | (bus.mreq && busy_k == mem_delay);
      bus.mrdata = mem_data;
    end
  end

  // Model: owner 0 = none, 1 = fetch, 2 = data; m_cycles = busy cycles already spent.
  int          m_own    = 0;
  int          m_cycles = 0;
  logic        e_mreq   = 1'b0;
  logic        e_mwe    = 1'b0;
  logic [31:0] e_maddr  = '0;
  logic [31:0] e_mwdata = '0;
  logic [31:0] e_irdata = '0;
  logic [31:0] e_drdata = '0;
  logic        e_iack   = 1'b0;
  logic        e_dack   = 1'b0;
  logic        e_err    = 1'b0;
  logic        e_sticky = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own <= 0; m_cycles <= 0;
      e_mreq <= 1'b0; e_mwe <= 1'b0; e_maddr <= '0; e_mwdata <= '0;
      e_irdata <= '0; e_drdata <= '0; e_iack <= 1'b0; e_dack <= 1'b0;
      e_err <= 1'b0; e_sticky <= 1'b0;
    end else begin
      e_iack <= 1'b0;
      e_dack <= 1'b0;
      e_err  <= 1'b0;
      if (m_own == 0) begin
        if (bus.dreq && !e_dack) begin
          m_own <= 2; m_cycles <= 0; e_mreq <= 1'b1;
          e_mwe <= bus.dwe; e_maddr <= bus.daddr; e_mwdata <= bus.dwdata;
        end else if (bus.ireq && !e_iack) begin
          m_own <= 1; m_cycles <= 0; e_mreq <= 1'b1;
          e_mwe <= 1'b0; e_maddr <= bus.iaddr;
        end
      end else if (bus.mready) begin
        m_own <= 0; e_mreq <= 1'b0; e_mwe <= 1'b0;
        if (m_own == 1) begin
          e_iack <= 1'b1; e_irdata <= bus.mrdata;
        end else begin
          e_dack <= 1'b1;
          if (!e_mwe) e_drdata <= bus.mrdata;
        end
      end else if (m_cycles + 1 == TMO) begin
        m_own <= 0; e_mreq <= 1'b0; e_mwe <= 1'b0; e_err <= 1'b1; e_sticky <= 1'b1;
        if (m_own == 1) begin
          e_iack <= 1'b1; e_irdata <= '1;
        end else begin
          e_dack <= 1'b1; e_drdata <= '1;
        end
      end else begin
        m_cycles <= m_cycles + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("mreq", 32'(bus.mreq), 32'(e_mreq));
      checkOutput("maddr", bus.maddr, e_maddr);
      checkOutput("mwdata", bus.mwdata, e_mwdata);
      if (e_mreq) checkOutput("mwe", 32'(bus.mwe), 32'(e_mwe));
      checkOutput("iack", 32'(bus.iack), 32'(e_iack));
      checkOutput("dack", 32'(bus.dack), 32'(e_dack));
      checkOutput("irdata", bus.irdata, e_irdata);
      checkOutput("drdata", bus.drdata, e_drdata);
      checkOutput("err", 32'(bus.err), 32'(e_err));
      checkOutput("err_sticky", 32'(bus.err_sticky), 32'(e_sticky));
      checkOutput("istall", 32'(bus.istall), 32'(bus.ireq & ~e_iack));
      checkOutput("dstall", 32'(bus.dstall), 32'(bus.dreq & ~e_dack));
    end
  end

  task automatic waitAck(input bit want_d, input int budget,
                         output int cyc, output int mreq_cyc, output int stall_cyc);
    bit got = 1'b0;
    cyc = 0; mreq_cyc = 0; stall_cyc = 0;
    while (!got && cyc < budget) begin
      stepCycle();
      cyc++;
      if (want_d ? bus.dack : bus.iack) got = 1'b1;
      else begin
        if (bus.mreq) mreq_cyc++;
        if (want_d ? bus.dstall : bus.istall) stall_cyc++;
      end
    end
    checkOutput(want_d ? "dack_seen" : "iack_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  int          cyc, mcyc, scyc, acks;
  logic [31:0] ia, da;
  logic        ir, dr, stop, prev_m;
  logic        grants[$];

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    chk_en = 1'b1;
    stepCycle();
    checkOutput("rst_mreq", 32'(bus.mreq), 32'd0);
    checkOutput("rst_maddr", bus.maddr, 32'd0);
    checkOutput("rst_irdata", bus.irdata, 32'd0);
    checkOutput("rst_sticky", 32'(bus.err_sticky), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    stepCycle();

    $display("[TB] fetch alone");
    mem_delay = 0; mem_data = 32'h8C020004;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
    waitAck(1'b0, 10, cyc, mcyc, scyc);
    checkOutput("fetch_latency", cyc, 32'd2);
    checkOutput("fetch_mreq_cycles", mcyc, 32'd1);
    checkOutput("fetch_irdata", bus.irdata, 32'h8C020004);
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, '0, '0);
    stepCycle();

    $display("[TB] store with priority");
    mem_data = 32'hDEADBEEF;
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b1, 32'h54, 32'h7);
    stepCycle();
    checkOutput("store_mwe", 32'(bus.mwe), 32'd1);
    checkOutput("store_maddr", bus.maddr, 32'h54);
    checkOutput("store_mwdata", bus.mwdata, 32'h7);
    checkOutput("store_istall", 32'(bus.istall), 32'd1);
    waitAck(1'b1, 10, cyc, mcyc, scyc);
    checkOutput("store_drdata", bus.drdata, 32'h0);
    checkOutput("store_mwe_dropped", 32'(bus.mwe), 32'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, '0, '0);
    stepCycle();
    checkOutput("store_then_fetch_maddr", bus.maddr, 32'h44);
    checkOutput("store_then_fetch_mreq", 32'(bus.mreq), 32'd1);
    waitAck(1'b0, 10, cyc, mcyc, scyc);
    checkOutput("store_then_fetch_lat", cyc, 32'd1);
    checkOutput("store_then_fetch_irdata", bus.irdata, 32'hDEADBEEF);
    checkOutput("store_drdata_kept", bus.drdata, 32'h0);
    applyStimulus(1'b0, 32'h44, 1'b0, 1'b0, '0, '0);
    stepCycle();

    $display("[TB] wait states");
    mem_delay = 3; mem_data = 32'h1234;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h60, '0);
    waitAck(1'b1, 20, cyc, mcyc, scyc);
    checkOutput("wait_latency", cyc, 32'd5);
    checkOutput("wait_mreq_cycles", mcyc, 32'd4);
    checkOutput("wait_dstall_cycles", scyc, 32'd4);
    checkOutput("wait_drdata", bus.drdata, 32'h1234);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h60, '0);
    stepCycle();

    $display("[TB] contention");
    mem_delay = 0; mem_data = 32'h55;
    ia = 32'h1000; da = 32'h2000; ir = 1'b1; dr = 1'b1; stop = 1'b0; prev_m = 1'b0;
    applyStimulus(ir, ia, dr, 1'b0, da, '0);
    for (int i = 0; i < 40 && (ir || dr); i++) begin
      stepCycle();
      if (i == 16) stop = 1'b1;
      if (bus.mreq && !prev_m) grants.push_back(bus.maddr[13]);
      prev_m = bus.mreq;
      if (bus.iack) begin
        if (stop) ir = 1'b0; else ia = ia + 32'd4;
      end
      if (bus.dack) begin
        if (stop) dr = 1'b0; else da = da + 32'd4;
      end
      applyStimulus(ir, ia, dr, 1'b0, da, '0);
    end
    checkOutput("contention_drained", 32'(ir | dr), 32'd0);
    checkOutput("contention_grants_ge6", 32'(grants.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      checkOutput($sformatf("grant_order_%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    stepCycle();

    $display("[TB] timeout");
    mem_delay = 255; mem_data = 32'h9999;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h80, '0);
    waitAck(1'b1, 20, cyc, mcyc, scyc);
    checkOutput("tmo_latency", cyc, 32'd5);
    checkOutput("tmo_mreq_cycles", mcyc, 32'd4);
    checkOutput("tmo_drdata", bus.drdata, 32'hFFFFFFFF);
    checkOutput("tmo_err", 32'(bus.err), 32'd1);
    checkOutput("tmo_sticky", 32'(bus.err_sticky), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h80, '0);
    force_ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      if (bus.iack || bus.dack) acks++;
    end
    force_ready = 1'b0;
    checkOutput("late_mready_acks", acks, 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("tmo_err_pulse_gone", 32'(bus.err), 32'd0);
    checkOutput("tmo_sticky_held", 32'(bus.err_sticky), 32'd1);

    $display("[TB] reset mid-operation");
    mem_delay = 255;
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0);
    stepCycle();
    stepCycle();
    checkOutput("rst_mid_busy", 32'(bus.mreq), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_mreq", 32'(bus.mreq), 32'd0);
    checkOutput("rst_mid_iack", 32'(bus.iack), 32'd0);
    checkOutput("rst_mid_maddr", bus.maddr, 32'd0);
    checkOutput("rst_mid_sticky", 32'(bus.err_sticky), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mem_delay = 0; mem_data = 32'hCAFE0001;
    waitAck(1'b0, 10, cyc, mcyc, scyc);
    checkOutput("rst_regrant_irdata", bus.irdata, 32'hCAFE0001);
    applyStimulus(1'b0, 32'h300, 1'b0, 1'b0, '0, '0);
    stepCycle();
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter for the pipelined MIPS core. It shares a single external single-port memory between the instruction-fetch port and the data (load/store) port. Each transaction runs through a small state machine with a bounded-wait timeout, and the block produces the stall qualifiers the hazard unit uses to freeze the pipeline while a port waits.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum busy cycles without mready before abort; counter is 8 bits, legal range 1..255

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- ireq  in  1  fetch request; held with iaddr stable until iack
- iaddr  in  AW  fetch byte address
- irdata  out  DW  fetched word, valid while iack=1
- iack  out  1  one-cycle fetch completion pulse
- istall  out  1  ireq & ~iack (combinational)
- dreq  in  1  data request; held with dwe/daddr/dwdata stable until dack
- dwe  in  1  1 = store, 0 = load
- daddr  in  AW  data byte address
- dwdata  in  DW  store data
- drdata  out  DW  load data, valid while dack=1
- dack  out  1  one-cycle data completion pulse
- dstall  out  1  dreq & ~dack (combinational)
- mreq  out  1  memory request, registered
- mwe  out  1  memory write enable, registered
- maddr  out  AW  memory address, registered
- mwdata  out  DW  memory write data, registered
- mrdata  in  DW  memory read data, sampled when mready=1
- mready  in  1  memory completion; may be high in the first busy cycle
- err  out  1  one-cycle pulse on timeout abort
- err_sticky  out  1  set on any timeout; cleared only by reset

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE arbitration uses masked requests: dreq_m = dreq & ~dack, ireq_m = ireq & ~iack. This keeps a port from being re-granted in the same cycle its ack is high.
- IDLE with dreq_m: go to DBUSY. Latch daddr, dwdata, dwe into maddr, mwdata, mwe. Set mreq=1 and clear the counter.
- IDLE with ireq_m and no dreq_m: go to IBUSY. Latch iaddr into maddr, set mwe=0, set mreq=1, clear the counter.
- Data has fixed priority. Because of the ack mask, a waiting fetch is granted in the cycle dack is high, so the two ports alternate under continuous contention.
- BUSY with mready=1: return to IDLE, drop mreq and mwe, and pulse the owning port's ack next cycle.
  - IBUSY: irdata <= mrdata.
  - DBUSY load: drdata <= mrdata.
  - DBUSY store: drdata holds its previous value.
- BUSY with mready=0: increment the counter. When the counter equals TIMEOUT-1:
  - return to IDLE and drop mreq;
  - pulse the owner's ack with its rdata = all ones;
  - pulse err and set err_sticky.
- mready seen in IDLE is ignored.
- maddr and mwdata hold their last values when idle. Only mreq qualifies them.
- The arbiter does not inspect addresses and does not reorder requests.

## Timing
- Reset values: state IDLE, mreq=0, mwe=0, maddr=0, mwdata=0, irdata=0, drdata=0, iack=0, dack=0, err=0, err_sticky=0, counter=0.
- Reset asserted mid-transaction takes effect immediately (asynchronous). mreq drops without waiting for mready, and no ack is issued.
- Latency from the request-sample edge:
  - grant edge E0 sets mreq=1;
  - mready high in cycle k≥0 after E0 gives ack high in cycle k+1;
  - minimum is ack two cycles after req is first seen in IDLE.
- Timeout: with mready never high, mreq stays high for exactly TIMEOUT cycles. ack and err coincide on the next cycle.
- Throughput: at most one transaction per 2 cycles (one busy cycle plus the ack/IDLE cycle).
- Simultaneous ireq and dreq in IDLE: data is granted and fetch waits with istall=1.
- A requester must deassert its req, or present a new request, on the edge at which its ack is high.

## Test plan
- Fetch alone: ireq=1, iaddr=0x40, mready high in the first busy cycle, mrdata=0x8C020004. Required: mreq/maddr=0x40 for 1 cycle, then iack=1 with irdata=0x8C020004, 2 cycles after request.
- Store with priority: ireq and dreq asserted together, dwe=1, daddr=0x54, dwdata=7. Required: DBUSY first with mwe=1, maddr=0x54, mwdata=7. dack pulses, and in the same cycle the fetch is granted; iack follows 2 cycles later. drdata is unchanged.
- Contention: ireq and dreq held continuously, with new addresses supplied after each ack. Required: grants strictly alternate D, I, D, I; neither port starves.
- Wait states: load with mready delayed 3 cycles, mrdata=0x1234. Required: mreq high 4 cycles, dack on the 5th cycle with drdata=0x1234, dstall high for the whole wait.
- Timeout: TIMEOUT=4, dreq load, mready held 0. Required: mreq high 4 cycles, then dack=1 with drdata=0xFFFFFFFF and err=1, err_sticky stays 1; a late mready in IDLE produces no ack.
- Reset mid-operation: assert reset during IBUSY. Required: mreq=0 asynchronously, no iack, all outputs at reset values; after release, a pending ireq is re-granted normally.
